// File: rtl/lcd_bus_scheduler.sv
// lcd_bus_scheduler
//   Shares one HD44780-style LCD write bus between two requesters:
//   port 0 (init sequencer) and port 1 (application). Each granted write
//   runs SETUP -> EN_HI -> HOLD -> WAIT -> DONE with cycle-exact timing.
//   When both ports request at once, they are granted in round-robin order.
//
// Parameters
//   SETUP_CYC  : RS/DATA setup cycles before EN rises
//   EN_CYC     : EN high width in cycles
//   HOLD_CYC   : RS/DATA hold cycles after EN falls
//   SHORT_WAIT : execution wait for normal commands
//   LONG_WAIT  : execution wait for clear/home commands
//
// Ports
//   Clock, Reset_n             : rising-edge clock, async active-low reset
//   REQx, RSx, DATAx, LONGx    : write request and its fields, per port
//   ACKx                       : one-cycle completion pulse, per port
//   LCD_RS/LCD_RW/LCD_EN/LCD_DATA : display bus (RW is always 0)
//   BUSY                       : high whenever the FSM is not idle
//   OWNER                      : port currently or most recently granted
//
// Every output comes directly from a flop.

module lcd_bus_scheduler #(
  parameter int SETUP_CYC  = 2,
  parameter int EN_CYC     = 25,
  parameter int HOLD_CYC   = 2,
  parameter int SHORT_WAIT = 2500,
  parameter int LONG_WAIT  = 100000
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic       RS0,
  input  logic       RS1,
  input  logic [7:0] DATA0,
  input  logic [7:0] DATA1,
  input  logic       LONG0,
  input  logic       LONG1,
  output logic       ACK0,
  output logic       ACK1,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic [7:0] LCD_DATA,
  output logic       BUSY,
  output logic       OWNER
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    EN_HI,
    HOLD,
    WAIT,
    DONE
  } state_t;

  // Counter reload values: each timed state lasts N cycles, so the counter
  // is loaded with N-1 on entry and the state exits on the edge where it is 0.
  localparam logic [16:0] SETUP_LD = 17'(SETUP_CYC - 1);
  localparam logic [16:0] EN_LD    = 17'(EN_CYC - 1);
  localparam logic [16:0] HOLD_LD  = 17'(HOLD_CYC - 1);
  localparam logic [16:0] SHORT_LD = 17'(SHORT_WAIT - 1);
  localparam logic [16:0] LONG_LD  = 17'(LONG_WAIT - 1);

  state_t      state;
  logic [16:0] cnt;
  logic        long_q;
  logic        grant_any;
  logic        grant_port;

  // Arbitration: a lone requester wins outright; with both pending, the
  // port that did not own the bus last time wins.
  always_comb begin
    grant_any  = REQ0 | REQ1;
    grant_port = REQ1 & (~REQ0 | ~OWNER);
  end

  // Sequencer. LCD_RS/LCD_DATA double as the captured request fields, so
  // they only change at a grant and hold their value while idle. LONG is
  // captured separately because it is only consumed when WAIT is entered.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      long_q   <= 1'b0;
      ACK0     <= 1'b0;
      ACK1     <= 1'b0;
      LCD_RS   <= 1'b0;
      LCD_RW   <= 1'b0;
      LCD_EN   <= 1'b0;
      LCD_DATA <= 8'h00;
      BUSY     <= 1'b0;
      OWNER    <= 1'b1;
    end else begin
      ACK0   <= 1'b0;
      ACK1   <= 1'b0;
      LCD_RW <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            OWNER    <= grant_port;
            LCD_RS   <= grant_port ? RS1 : RS0;
            LCD_DATA <= grant_port ? DATA1 : DATA0;
            long_q   <= grant_port ? LONG1 : LONG0;
            BUSY     <= 1'b1;
            cnt      <= SETUP_LD;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            LCD_EN <= 1'b1;
            cnt    <= EN_LD;
            state  <= EN_HI;
          end else begin
            cnt <= cnt - 17'd1;
          end
        end
        EN_HI: begin
          if (cnt == '0) begin
            LCD_EN <= 1'b0;
            cnt    <= HOLD_LD;
            state  <= HOLD;
          end else begin
            cnt <= cnt - 17'd1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            cnt   <= long_q ? LONG_LD : SHORT_LD;
            state <= WAIT;
          end else begin
            cnt <= cnt - 17'd1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            ACK0  <= ~OWNER;
            ACK1  <= OWNER;
            state <= DONE;
          end else begin
            cnt <= cnt - 17'd1;
          end
        end
        DONE: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          LCD_EN <= 1'b0;
          BUSY   <= 1'b0;
          cnt    <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// tb_lcd_bus_scheduler
//   Directed bench for lcd_bus_scheduler. LONG_WAIT is shortened to 6000
//   so the long-wait transaction stays short; all other timing parameters
//   are at their defaults. Edge numbers in comments count rising edges
//   from the grant edge E0. Outputs are sampled 1 ns after a rising edge.

module tb_lcd_bus_scheduler;

  localparam int LONG_W = 6000;
  // Hand-derived edge offsets from the grant edge to the ACK edge:
  // 2 setup + 25 EN + 2 hold = 29 edges to reach WAIT, then WAIT cycles.
  localparam int ACK_SHORT = 2529;
  localparam int ACK_LONG  = 6029;

  logic       Clock;
  logic       Reset_n;
  logic       REQ0, REQ1, RS0, RS1, LONG0, LONG1;
  logic [7:0] DATA0, DATA1;
  logic       ACK0, ACK1, LCD_RS, LCD_RW, LCD_EN, BUSY, OWNER;
  logic [7:0] LCD_DATA;

  int errors = 0;
  int checks = 0;
  int ack0_pulses = 0;
  int ack1_pulses = 0;
  int ack_overlap = 0;

  lcd_bus_scheduler #(
    .SETUP_CYC (2),
    .EN_CYC    (25),
    .HOLD_CYC  (2),
    .SHORT_WAIT(2500),
    .LONG_WAIT (LONG_W)
  ) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .REQ0    (REQ0),
    .REQ1    (REQ1),
    .RS0     (RS0),
    .RS1     (RS1),
    .DATA0   (DATA0),
    .DATA1   (DATA1),
    .LONG0   (LONG0),
    .LONG1   (LONG1),
    .ACK0    (ACK0),
    .ACK1    (ACK1),
    .LCD_RS  (LCD_RS),
    .LCD_RW  (LCD_RW),
    .LCD_EN  (LCD_EN),
    .LCD_DATA(LCD_DATA),
    .BUSY    (BUSY),
    .OWNER   (OWNER)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Tally ACK pulses and any overlap between the two ACKs.
  always @(negedge Clock) begin
    if (ACK0) ack0_pulses++;
    if (ACK1) ack1_pulses++;
    if (ACK0 && ACK1) ack_overlap++;
  end

  // Hard time limit so a stuck run still ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic applyStimulus(input int port, input logic req, input logic rs,
                               input logic [7:0] data, input logic lng);
    if (port == 0) begin
      REQ0 = req; RS0 = rs; DATA0 = data; LONG0 = lng;
    end else begin
      REQ1 = req; RS1 = rs; DATA1 = data; LONG1 = lng;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 1'b0);

    // ---------------- reset state ----------------
    tick(3);
    checkOutput("rst_en",    LCD_EN,   0);
    checkOutput("rst_rs",    LCD_RS,   0);
    checkOutput("rst_rw",    LCD_RW,   0);
    checkOutput("rst_data",  LCD_DATA, 8'h00);
    checkOutput("rst_ack0",  ACK0,     0);
    checkOutput("rst_ack1",  ACK1,     0);
    checkOutput("rst_busy",  BUSY,     0);
    checkOutput("rst_owner", OWNER,    1);
    Reset_n = 1'b1;
    tick(2);
    checkOutput("idle_no_req_busy", BUSY, 0);

    // ---------------- single short request on port 0 ----------------
    applyStimulus(0, 1'b1, 1'b0, 8'h38, 1'b0);
    tick(1); // E0
    checkOutput("s_grant_data",  LCD_DATA, 8'h38);
    checkOutput("s_grant_rs",    LCD_RS,   0);
    checkOutput("s_grant_busy",  BUSY,     1);
    checkOutput("s_grant_owner", OWNER,    0);
    checkOutput("s_grant_en",    LCD_EN,   0);
    tick(1); // E1
    checkOutput("s_e1_en", LCD_EN, 0);
    tick(1); // E2
    checkOutput("s_e2_en", LCD_EN, 1);
    tick(24); // E26
    checkOutput("s_e26_en", LCD_EN, 1);
    tick(1); // E27
    checkOutput("s_e27_en", LCD_EN, 0);
    tick(1); // E28, in HOLD
    checkOutput("s_hold_data", LCD_DATA, 8'h38);
    checkOutput("s_hold_en",   LCD_EN,   0);
    tick(ACK_SHORT - 1 - 28); // E2528
    checkOutput("s_pre_ack0", ACK0, 0);
    checkOutput("s_pre_busy", BUSY, 1);
    tick(1); // E2529
    checkOutput("s_ack0", ACK0, 1);
    checkOutput("s_ack1", ACK1, 0);
    checkOutput("s_ack_busy", BUSY, 1);
    applyStimulus(0, 1'b0, 1'b0, 8'h38, 1'b0);
    tick(1); // E2530
    checkOutput("s_post_ack0", ACK0, 0);
    checkOutput("s_post_busy", BUSY, 0);
    tick(2);
    checkOutput("s_idle_busy", BUSY, 0);
    checkOutput("s_idle_data", LCD_DATA, 8'h38);

    // ---------------- long wait on port 1 ----------------
    ack0_pulses = 0;
    ack1_pulses = 0;
    applyStimulus(1, 1'b1, 1'b0, 8'h01, 1'b1);
    tick(1); // E0
    checkOutput("l_grant_owner", OWNER,    1);
    checkOutput("l_grant_data",  LCD_DATA, 8'h01);
    tick(ACK_SHORT); // a short wait would have acked here
    checkOutput("l_no_short_ack", ACK1, 0);
    tick(ACK_LONG - 1 - ACK_SHORT);
    checkOutput("l_pre_ack1", ACK1, 0);
    checkOutput("l_pre_busy", BUSY, 1);
    tick(1);
    checkOutput("l_ack1", ACK1, 1);
    applyStimulus(1, 1'b0, 1'b0, 8'h01, 1'b1);
    tick(1);
    checkOutput("l_ack0_count", ack0_pulses, 0);
    checkOutput("l_ack1_count", ack1_pulses, 1);
    checkOutput("l_idle_busy",  BUSY, 0);

    // ---------------- inputs changed mid-transaction ----------------
    applyStimulus(1, 1'b1, 1'b1, 8'hA7, 1'b0);
    tick(1); // E0
    checkOutput("m_grant_data", LCD_DATA, 8'hA7);
    checkOutput("m_grant_rs",   LCD_RS,   1);
    tick(10); // E10, EN high
    checkOutput("m_en_hi", LCD_EN, 1);
    applyStimulus(1, 1'b1, 1'b0, 8'h55, 1'b1);
    tick(10);
    checkOutput("m_during_data", LCD_DATA, 8'hA7);
    checkOutput("m_during_rs",   LCD_RS,   1);
    tick(ACK_SHORT - 20); // E2529; LONG1=1 after grant must not stretch WAIT
    checkOutput("m_ack1", ACK1, 1);
    checkOutput("m_ack_data", LCD_DATA, 8'hA7);
    applyStimulus(1, 1'b0, 1'b0, 8'h55, 1'b0);
    tick(3);
    checkOutput("m_idle_data", LCD_DATA, 8'hA7);
    checkOutput("m_idle_busy", BUSY, 0);

    // ---------------- reset abort during EN_HI ----------------
    ack0_pulses = 0;
    ack1_pulses = 0;
    applyStimulus(1, 1'b1, 1'b1, 8'h22, 1'b0);
    tick(1); // E0, OWNER was 1 and only port 1 requests
    checkOutput("r_grant_owner", OWNER, 1);
    tick(5);
    checkOutput("r_en_hi", LCD_EN, 1);
    #2;
    applyStimulus(0, 1'b1, 1'b0, 8'hA0, 1'b0);
    applyStimulus(1, 1'b1, 1'b1, 8'hB1, 1'b0);
    Reset_n = 1'b0;
    #1;
    checkOutput("r_abort_en",    LCD_EN,   0);
    checkOutput("r_abort_busy",  BUSY,     0);
    checkOutput("r_abort_ack1",  ACK1,     0);
    checkOutput("r_abort_owner", OWNER,    1);
    checkOutput("r_abort_data",  LCD_DATA, 8'h00);
    @(negedge Clock);
    Reset_n = 1'b1;
    tick(1); // first edge after release: both request, port 0 wins
    checkOutput("r_first_owner", OWNER,    0);
    checkOutput("r_first_data",  LCD_DATA, 8'hA0);
    checkOutput("r_first_busy",  BUSY,     1);
    checkOutput("r_no_ack",      ack1_pulses, 0);

    // ---------------- contention: both held high ----------------
    for (int k = 0; k < 4; k++) begin
      logic port;
      port = k[0];
      checkOutput($sformatf("c%0d_owner", k), OWNER, port);
      checkOutput($sformatf("c%0d_data", k), LCD_DATA, port ? 8'hB1 : 8'hA0);
      checkOutput($sformatf("c%0d_rs", k), LCD_RS, port);
      tick(ACK_SHORT);
      checkOutput($sformatf("c%0d_ack0", k), ACK0, !port);
      checkOutput($sformatf("c%0d_ack1", k), ACK1, port);
      if (k == 3) begin
        applyStimulus(0, 1'b0, 1'b0, 8'hA0, 1'b0);
        applyStimulus(1, 1'b0, 1'b1, 8'hB1, 1'b0);
      end
      tick(1); // DONE -> IDLE
      checkOutput($sformatf("c%0d_idle_busy", k), BUSY, 0);
      if (k < 3) tick(1); // next grant
    end
    checkOutput("c_ack0_count", ack0_pulses, 2);
    checkOutput("c_ack1_count", ack1_pulses, 2);

    // ---------------- REQ0 held through ACK0 ----------------
    applyStimulus(0, 1'b1, 1'b0, 8'h3C, 1'b0);
    tick(1); // grant, OWNER was 1
    checkOutput("h_first_owner", OWNER,    0);
    checkOutput("h_first_data",  LCD_DATA, 8'h3C);
    tick(ACK_SHORT);
    checkOutput("h_first_ack0", ACK0, 1);
    applyStimulus(0, 1'b1, 1'b0, 8'h0C, 1'b0);
    tick(1); // DONE -> IDLE, no grant yet
    checkOutput("h_gap_busy", BUSY,     0);
    checkOutput("h_gap_data", LCD_DATA, 8'h3C);
    checkOutput("h_gap_ack0", ACK0,     0);
    tick(1); // regrant with updated data
    checkOutput("h_second_busy",  BUSY,     1);
    checkOutput("h_second_data",  LCD_DATA, 8'h0C);
    checkOutput("h_second_owner", OWNER,    0);
    applyStimulus(0, 1'b0, 1'b0, 8'h0C, 1'b0);
    tick(ACK_SHORT);
    checkOutput("h_second_ack0", ACK0, 1);
    tick(2);
    checkOutput("h_end_busy", BUSY, 0);

    checkOutput("ack_overlap", ack_overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
